// File: rtl/nanci_edge_tx.sv
// nanci_edge_tx: queues packed {addr,data} words and drives one per SORT_CYCLES-clock slot onto a neighbour PE link.
// Defining NANCI_EDGE_TX_COUNT_EN adds o_sent_count, a saturating count of words sent.
module nanci_edge_tx #(
  parameter int ADDR_WIDTH  = 3,
  parameter int DATA_WIDTH  = 3,
  parameter int DEPTH       = 4,
  parameter int SORT_CYCLES = 1,
  parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] IDLE_WORD = '1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_valid,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_word,
  output logic                             o_ready,
  input  logic                             i_enable,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_PE,
  output logic                             o_link_valid,
  output logic                             o_busy
`ifdef NANCI_EDGE_TX_COUNT_EN
  ,
  output logic [7:0]                       o_sent_count
`endif
);

  localparam int W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(SORT_CYCLES - 1);

  typedef enum logic {IDLE, SLOT} state_t;

  state_t        state;
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [CW-1:0] slot_cnt;
  logic          push;
  logic          pop;
  logic          boundary;

  // Full is judged on the registered count, so a push while full is dropped even if a pop frees a slot.
  assign o_ready  = (count != FULL);
  assign push     = i_valid && o_ready;
  assign boundary = (state == IDLE) || (slot_cnt == LAST);
  assign pop      = boundary && i_enable && (count != '0);
  assign o_busy   = (count != '0) || (state == SLOT);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A pop always restarts the slot, which is what lets words stream back-to-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      slot_cnt     <= '0;
      o_PE         <= IDLE_WORD;
      o_link_valid <= 1'b0;
    end else if (pop) begin
      state        <= SLOT;
      slot_cnt     <= '0;
      o_PE         <= mem[rd_ptr];
      o_link_valid <= 1'b1;
    end else if (!boundary) begin
      slot_cnt     <= slot_cnt + 1'b1;
    end else begin
      state        <= IDLE;
      slot_cnt     <= '0;
      o_PE         <= IDLE_WORD;
      o_link_valid <= 1'b0;
    end
  end

`ifdef NANCI_EDGE_TX_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      o_sent_count <= '0;
    else if (pop && o_sent_count != 8'hff)
      o_sent_count <= o_sent_count + 8'd1;
  end
`endif

endmodule
